// File: rtl/mem_stage_buffered_pkg.sv
// Shared widths and FSM encoding for the buffered pipeline memory stage.
// The width defaults mirror the ISA-wide register and register-address sizes.
package mem_stage_buffered_pkg;

  localparam int LEN_REGISTER    = 32;
  localparam int LEN_REG_ADDRESS = 4;
  localparam int WBUF_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_write_buffer.sv
// Posted-write FIFO holding {address, data} pairs until the external memory
// accepts them. DEPTH must be a power of two so that the pointers wrap naturally.
module mem_write_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count
  // define which entries are valid, so clearing them is enough.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_buffered.sv
// Pipeline MEM stage in front of a multi-cycle req/ack data memory. Stores
// retire into a posted-write buffer; loads wait until all posted writes drain.
module mem_stage_buffered
  import mem_stage_buffered_pkg::*;
#(
  parameter int DATA_W     = LEN_REGISTER,
  parameter int ADDR_W     = LEN_REGISTER,
  parameter int REG_ADDR_W = LEN_REG_ADDRESS,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_enable_in,
  input  logic [REG_ADDR_W-1:0] dest_reg_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     store_data_in,
  output logic                  mem_read_out,
  output logic                  wb_enable_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] dest_reg_out,
  output logic [DATA_W-1:0]     memory_data_out,
  output logic [DATA_W-1:0]     result_out,
  output logic                  mem_ready,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [ADDR_W-1:0]     ext_addr,
  output logic [DATA_W-1:0]     ext_wdata,
  input  logic                  ext_ack,
  input  logic [DATA_W-1:0]     ext_rdata
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  mem_state_e        state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_q;
  logic              wbuf_full, wbuf_empty;
  logic [CNT_W-1:0]  wbuf_count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              load_op, store_op, advance, push, pop, start_read;

  // A simultaneous read+write is treated purely as a load.
  assign load_op  = mem_read_in;
  assign store_op = mem_write_in & ~mem_read_in;

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    mem_ready = 1'b1;
    if (load_op)       mem_ready = (state == ST_RD_DONE);
    else if (store_op) mem_ready = ~wbuf_full;
  end

  assign advance    = mem_ready & ~freeze;
  assign push       = store_op & advance;
  assign pop        = (state == ST_WR_REQ) & ext_ack & ~wbuf_empty;
  assign start_read = (state == ST_IDLE) & (wbuf_count == '0) & mem_read_in;
  assign result_out = mem_read_in ? rd_q : alu_result_in;

  mem_write_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (alu_result_in[ADDR_W-1:0]),
    .push_data (store_data_in),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (wbuf_full),
    .empty     (wbuf_empty),
    .count     (wbuf_count)
  );

  // Posted writes always drain before a read starts, keeping memory order.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wbuf_count != '0) state_nxt = ST_WR_REQ;
        else if (mem_read_in) state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ:  if (ext_ack) state_nxt = ST_IDLE;
      ST_RD_REQ:  if (ext_ack) state_nxt = ST_RD_DONE;
      ST_RD_DONE: if (!freeze) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign ext_req   = (state == ST_WR_REQ) | (state == ST_RD_REQ);
  assign ext_we    = (state == ST_WR_REQ);
  assign ext_addr  = ext_we ? head_addr : rd_addr;
  assign ext_wdata = ext_we ? head_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      rd_q    <= '0;
    end else begin
      state <= state_nxt;
      if (start_read) rd_addr <= alu_result_in[ADDR_W-1:0];
      if ((state == ST_RD_REQ) && ext_ack) rd_q <= ext_rdata;
    end
  end

  // MEM/WB register: freeze holds everything, a stall inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_out    <= 1'b0;
      wb_enable_out   <= 1'b0;
      alu_result_out  <= '0;
      dest_reg_out    <= '0;
      memory_data_out <= '0;
    end else if (freeze) begin
      mem_read_out    <= mem_read_out;
      wb_enable_out   <= wb_enable_out;
    end else if (advance) begin
      mem_read_out    <= mem_read_in;
      wb_enable_out   <= wb_enable_in;
      alu_result_out  <= alu_result_in;
      dest_reg_out    <= dest_reg_in;
      memory_data_out <= rd_q;
    end else begin
      mem_read_out    <= 1'b0;
      wb_enable_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_buffered.sv
// Directed bench for mem_stage_buffered with a small req/ack memory responder
// whose acknowledge latency and enable are steered by the stimulus.
module tb_mem_stage_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        mem_read_in, mem_write_in, wb_enable_in;
  logic [3:0]  dest_reg_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        mem_read_out, wb_enable_out;
  logic [31:0] alu_result_out, memory_data_out, result_out;
  logic [3:0]  dest_reg_out;
  logic        mem_ready, ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack, mem_ack, stray_ack;

  int          checks = 0;
  int          errors = 0;
  logic        ack_en;
  int          ack_lat;
  int          wait_cnt;
  logic [31:0] rd_data;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  assign ext_ack   = mem_ack | stray_ack;
  assign ext_rdata = rd_data;

  always #5 clk = ~clk;

  mem_stage_buffered dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .wb_enable_in    (wb_enable_in),
    .dest_reg_in     (dest_reg_in),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .mem_read_out    (mem_read_out),
    .wb_enable_out   (wb_enable_out),
    .alu_result_out  (alu_result_out),
    .dest_reg_out    (dest_reg_out),
    .memory_data_out (memory_data_out),
    .result_out      (result_out),
    .mem_ready       (mem_ready),
    .ext_req         (ext_req),
    .ext_we          (ext_we),
    .ext_addr        (ext_addr),
    .ext_wdata       (ext_wdata),
    .ext_ack         (ext_ack),
    .ext_rdata       (ext_rdata)
  );

  // Memory model: acks ack_lat negedges after a request is seen; logs writes.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst || !ext_req) begin
      wait_cnt = 0;
    end else if (ack_en) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= ack_lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (ext_we) begin
          wr_addr_log.push_back(ext_addr);
          wr_data_log.push_back(ext_wdata);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic wb, input logic [3:0] dst,
                       input logic [31:0] alu, input logic [31:0] sd);
    mem_read_in   = rd;
    mem_write_in  = wr;
    wb_enable_in  = wb;
    dest_reg_in   = dst;
    alu_result_in = alu;
    store_data_in = sd;
    #1;
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_rd, seen_we;
    int writes_at_rd, bubble_bad;

    rst = 1'b1; freeze = 1'b0; stray_ack = 1'b0; mem_ack = 1'b0;
    ack_en = 1'b0; ack_lat = 2; rd_data = 32'h0; wait_cnt = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ext_req", ext_req, 1'b0);
    check("rst_count", dut.u_wbuf.count, 0);
    check("rst_wb_en", wb_enable_out, 1'b0);
    check("rst_mem_data", memory_data_out, 32'h0);

    // 1: single store, posted, drained with ack two cycles after req
    ack_en = 1'b1; ack_lat = 2; clear_log();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'h40, 32'h1234);
    check("t1_ready_same_cycle", mem_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    check("t1_count_after_push", dut.u_wbuf.count, 1);
    for (n = 0; n < 5 && !ext_req; n++) tick();
    check("t1_req_rise", ext_req, 1'b1);
    check("t1_we", ext_we, 1'b1);
    check("t1_addr", ext_addr, 32'h40);
    check("t1_wdata", ext_wdata, 32'h1234);
    for (n = 0; n < 10 && ext_req; n++) tick();
    check("t1_req_fall", ext_req, 1'b0);
    check("t1_count_drained", dut.u_wbuf.count, 0);
    check("t1_writes", wr_addr_log.size(), 1);

    // 2: five back-to-back stores into a depth-4 buffer, ack withheld
    ack_en = 1'b0; ack_lat = 1; clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      check("t2_ready_not_full", mem_ready, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 4'd2, 32'h110, 32'hA4);
    check("t2_ready_full", mem_ready, 1'b0);
    bubble_bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_ready !== 1'b0 || wb_enable_out !== 1'b0) bubble_bad++;
    end
    check("t2_stall_bubbles", bubble_bad, 0);
    ack_en = 1'b1;
    for (n = 0; n < 10 && !mem_ready; n++) tick();
    check("t2_ready_after_pop", mem_ready, 1'b1);
    check("t2_count_after_pop", dut.u_wbuf.count, 3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    check("t2_fifth_captured", wb_enable_out, 1'b1);
    for (n = 0; n < 60 && (ext_req || dut.u_wbuf.count != 0); n++) tick();
    check("t2_write_count", wr_addr_log.size(), 5);
    for (int i = 0; i < wr_addr_log.size() && i < 5; i++)
      check("t2_order", {wr_addr_log[i], wr_data_log[i]},
            {32'h100 + 32'(4 * i), 32'hA0 + 32'(i)});

    // 3: store then load of the same address; read waits for write ack
    ack_lat = 1; clear_log(); rd_data = 32'hBEEF;
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'h80, 32'h5555);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h80, 32'h0);
    check("t3_load_not_ready", mem_ready, 1'b0);
    seen_rd = 1'b0; writes_at_rd = -1; bubble_bad = 0;
    for (n = 0; n < 40 && !mem_ready; n++) begin
      tick();
      if (wb_enable_out !== 1'b0) bubble_bad++;
      if (ext_req && !ext_we && !seen_rd) begin
        seen_rd = 1'b1;
        writes_at_rd = wr_addr_log.size();
      end
    end
    check("t3_ready", mem_ready, 1'b1);
    check("t3_read_seen", seen_rd, 1'b1);
    check("t3_write_before_read", writes_at_rd, 1);
    check("t3_stall_bubbles", bubble_bad, 0);
    check("t3_forward", result_out, 32'hBEEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    check("t3_mem_data", memory_data_out, 32'hBEEF);
    check("t3_wb_en", wb_enable_out, 1'b1);
    check("t3_mem_read_out", mem_read_out, 1'b1);
    check("t3_dest", dest_reg_out, 4'd5);

    // 4: load reaches RD_DONE under freeze; held three cycles, then captured
    rst = 1'b1; tick(); rst = 1'b0;
    ack_lat = 2; rd_data = 32'hBEEF;
    drive(1'b1, 1'b0, 1'b1, 4'd7, 32'h90, 32'h0);
    for (n = 0; n < 10 && !ext_req; n++) tick();
    check("t4_read_req", ext_req, 1'b1);
    freeze = 1'b1;
    for (n = 0; n < 20 && !mem_ready; n++) tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_frozen_ready", mem_ready, 1'b1);
      check("t4_frozen_forward", result_out, 32'hBEEF);
      check("t4_frozen_wb_en", wb_enable_out, 1'b0);
      check("t4_frozen_mem_data", memory_data_out, 32'h0);
      tick();
    end
    freeze = 1'b0;
    #1;
    check("t4_ready_unfrozen", mem_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    check("t4_mem_data", memory_data_out, 32'hBEEF);
    check("t4_wb_en", wb_enable_out, 1'b1);
    check("t4_dest", dest_reg_out, 4'd7);

    // 5: reset during WR_REQ with two entries queued; stray ack afterwards
    ack_en = 1'b0; clear_log();
    drive(1'b0, 1'b1, 1'b1, 4'd3, 32'hC0, 32'h11);
    tick();
    drive(1'b0, 1'b1, 1'b1, 4'd3, 32'hC4, 32'h22);
    tick();
    freeze = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    for (n = 0; n < 5 && !ext_req; n++) tick();
    check("t5_wr_req", ext_req, 1'b1);
    check("t5_count_two", dut.u_wbuf.count, 2);
    check("t5_alu_held", alu_result_out, 32'hC4);
    rst = 1'b1;
    tick();
    check("t5_rst_req", ext_req, 1'b0);
    check("t5_rst_count", dut.u_wbuf.count, 0);
    check("t5_rst_alu", alu_result_out, 32'h0);
    check("t5_rst_wb_en", wb_enable_out, 1'b0);
    check("t5_rst_dest", dest_reg_out, 4'd0);
    rst = 1'b0; freeze = 1'b0;
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick(); tick();
    check("t5_stray_req", ext_req, 1'b0);
    check("t5_stray_count", dut.u_wbuf.count, 0);
    check("t5_stray_ready", mem_ready, 1'b1);

    // 6: read and write together are a load only
    ack_en = 1'b1; ack_lat = 1; clear_log(); rd_data = 32'h600D;
    drive(1'b1, 1'b1, 1'b1, 4'd9, 32'hA0, 32'h77);
    check("t6_not_ready", mem_ready, 1'b0);
    seen_we = 1'b0;
    for (n = 0; n < 20 && !mem_ready; n++) begin
      tick();
      if (ext_req && ext_we) seen_we = 1'b1;
    end
    check("t6_ready", mem_ready, 1'b1);
    check("t6_no_write_req", seen_we, 1'b0);
    check("t6_count", dut.u_wbuf.count, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    check("t6_mem_data", memory_data_out, 32'h600D);
    tick(); tick(); tick();
    check("t6_no_writes", wr_addr_log.size(), 0);
    check("t6_idle_req", ext_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
